// File: rtl/adc_stream_pkg.sv
// adc_stream_pkg: shared types and helpers for the ADC sample packer
package adc_stream_pkg;
  localparam int WORD_W = 32;
  localparam int KEEP_W = 4;
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [WORD_W-1:0] data;
  } entry_t;
  function automatic logic [WORD_W-1:0] pack_pair(input logic [15:0] s0, input logic [15:0] s1);
    return {s1, s0};
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through FIFO with full/empty/count
module stream_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == DEPTH[AW:0];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];
  // storage is left unreset; the pointers alone decide which entries are live
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  // pointer and occupancy bookkeeping; a pop frees room for a same-edge push
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/adc_stream_packer.sv
// adc_stream_packer: packs 12-bit ADC samples two per 32-bit AXI4-Stream word
module adc_stream_packer
  import adc_stream_pkg::*;
#(
  parameter int SAMPLE_W   = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                i_CMOS_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Start,
  output logic                o_ADC_Work,
  input  logic                i_Sample_Valid,
  input  logic [SAMPLE_W-1:0] i_Sample,
  input  logic                i_Sample_Last,
  output logic [WORD_W-1:0]   m_axis_tdata,
  output logic [KEEP_W-1:0]   m_axis_tkeep,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                o_Busy,
  output logic                o_Overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic slot_valid, last_pending, start_ok, accept, word_gen, null_gen, pop, full, empty, drop;
  logic [SAMPLE_W-1:0] slot;
  logic [CW-1:0] count;
  entry_t word, head, wr_entry;
  assign start_ok   = state == IDLE && i_Start;
  assign accept     = state == CAPTURE && i_Sample_Valid;
  assign word_gen   = accept & (slot_valid | i_Sample_Last);
  assign null_gen   = last_pending && count < CW'(FIFO_DEPTH);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign drop       = word_gen & full & ~pop;
  assign word.last  = i_Sample_Last;
  assign word.keep  = slot_valid ? 4'hF : 4'h3;
  assign word.data  = slot_valid ? pack_pair(16'(slot), 16'(i_Sample)) : pack_pair(16'(i_Sample), 16'h0);
  assign wr_entry   = word_gen ? word : '{last: 1'b1, keep: '0, data: '0};
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = head.data;
  assign m_axis_tkeep  = head.keep;
  assign m_axis_tlast  = head.last;
  assign o_ADC_Work    = state == CAPTURE;
  assign o_Busy        = state != IDLE;
  stream_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_CMOS_Clk),
    .rst_n (i_Rst_n),
    .push  (word_gen | null_gen),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // frame state register
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n)
    if (!i_Rst_n) state <= IDLE;
    else state <= state_nx;
  // start opens a frame, the last sample closes capture, the tlast handshake ends drain
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_Start) state_nx = CAPTURE;
      CAPTURE: if (accept && i_Sample_Last) state_nx = DRAIN;
      DRAIN:   if (pop && m_axis_tlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // half-word slot, sticky overflow and the pending-tlast recovery flag
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      slot_valid   <= 1'b0;
      slot         <= '0;
      last_pending <= 1'b0;
      o_Overflow   <= 1'b0;
    end else begin
      if (start_ok) slot_valid <= 1'b0;
      else if (accept) slot_valid <= ~slot_valid & ~i_Sample_Last;
      if (accept && !slot_valid) slot <= i_Sample;
      if (start_ok) o_Overflow <= 1'b0;
      else if (drop) o_Overflow <= 1'b1;
      if (drop && word.last) last_pending <= 1'b1;
      else if (null_gen) last_pending <= 1'b0;
    end
endmodule

// File: tb/tb_adc_stream_packer.sv
// tb_adc_stream_packer: directed frames checked against a packing/dropping model
module tb_adc_stream_packer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sv = 1'b0, sl = 1'b0, tready = 1'b0;
  logic [11:0] sample = '0;
  logic adc_work, tvalid, tlast, busy, ovf;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  int compared = 0, mismatched = 0, words_seen = 0;
  typedef struct {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  word_t exp_q[$];
  logic [11:0] smp [1000];
  bit stall_prev = 0;
  logic [36:0] word_prev = '0;

  always #5 clk = ~clk;

  adc_stream_packer dut (
    .i_CMOS_Clk     (clk),
    .i_Rst_n        (rst_n),
    .i_Start        (start),
    .o_ADC_Work     (adc_work),
    .i_Sample_Valid (sv),
    .i_Sample       (sample),
    .i_Sample_Last  (sl),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .o_Busy         (busy),
    .o_Overflow     (ovf)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected words of a frame: pairs packed low-first, odd tail half-filled,
  // words beyond keep_limit lost, a lost final word replaced by a null tlast word
  task automatic expect_frame(input int n, input int keep_limit);
    int nw;
    bit pair;
    word_t e;
    nw = (n + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      pair = (2 * w + 1) < n;
      e.d = 32'(smp[2*w]) + (pair ? (32'(smp[2*w+1]) << 16) : 32'd0);
      e.k = pair ? 4'hF : 4'h3;
      e.l = (w == nw - 1);
      if (keep_limit == 0 || w < keep_limit) exp_q.push_back(e);
      else if (e.l) exp_q.push_back('{32'd0, 4'h0, 1'b1});
    end
  endtask

  // tr_mode: 0 = tready low, 1 = tready high, 2 = tready alternating
  task automatic send_frame(input int n, input bit with_last, input int start_at, input int tr_mode);
    tready = (tr_mode == 1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      sv = 1'b1;
      sample = smp[i];
      sl = with_last && (i == n - 1);
      start = (i == start_at);
      tready = (tr_mode == 2) ? i[0] : (tr_mode == 1);
      step();
    end
    sv = 1'b0;
    sl = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tready = 1'b1;
    while (busy && n < 300) begin
      step();
      n++;
    end
    check(name, 40'(busy), 40'd0);
    step();
    step();
    check({name, "_drained"}, 40'(exp_q.size()), 40'd0);
  endtask

  // stream monitor: every handshake against the model, stalled words must hold
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) stall_prev = 0;
    else begin
      if (stall_prev) begin
        check("stall_valid", 40'(tvalid), 40'd1);
        check("stall_hold", 40'({tlast, tkeep, tdata}), 40'(word_prev));
      end
      if (tvalid && tready) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got %h, want no word", {tlast, tkeep, tdata});
        end else begin
          w = exp_q.pop_front();
          check("word_data", 40'(tdata), 40'(w.d));
          check("word_keep", 40'(tkeep), 40'(w.k));
          check("word_last", 40'(tlast), 40'(w.l));
        end
      end
      stall_prev = tvalid && !tready;
      word_prev = {tlast, tkeep, tdata};
    end
  end

  initial begin
    step();
    step();
    check("rst_tvalid", 40'(tvalid), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_adc_work", 40'(adc_work), 40'd0);
    check("rst_ovf", 40'(ovf), 40'd0);
    check("rst_out", 40'({tlast, tkeep, tdata}), 40'd0);
    rst_n = 1'b1;
    step();

    // basic 4-sample frame with a latency probe
    for (int i = 0; i < 4; i++) smp[i] = 12'(i + 1);
    expect_frame(4, 0);
    check("model_w0", 40'(exp_q[0].d), 40'h00020001);
    check("model_w1", 40'(exp_q[1].d), 40'h00040003);
    check("model_w1_last", 40'(exp_q[1].l), 40'd1);
    tready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("adc_work_on", 40'(adc_work), 40'd1);
    sv = 1'b1;
    sample = 12'h001;
    step();
    sample = 12'h002;
    step();
    check("latency_valid", 40'(tvalid), 40'd1);
    check("latency_data", 40'(tdata), 40'h00020001);
    sample = 12'h003;
    step();
    sample = 12'h004;
    sl = 1'b1;
    step();
    sv = 1'b0;
    sl = 1'b0;
    check("adc_work_off", 40'(adc_work), 40'd0);
    check("drain_busy", 40'(busy), 40'd1);
    wait_idle("t1_idle");

    // odd-length frame ends in a half word
    smp[0] = 12'hABC;
    smp[1] = 12'h123;
    smp[2] = 12'hFFF;
    expect_frame(3, 0);
    check("model_half_data", 40'(exp_q[1].d), 40'h00000FFF);
    check("model_half_keep", 40'(exp_q[1].k), 40'h3);
    send_frame(3, 1, -1, 1);
    wait_idle("t2_idle");

    // overflow with tready held low, then a null tlast word
    for (int i = 0; i < 40; i++) smp[i] = 12'(i + 256);
    expect_frame(40, 16);
    check("model_ovf_len", 40'(exp_q.size()), 40'd17);
    check("model_null_keep", 40'(exp_q[16].k), 40'h0);
    send_frame(40, 1, -1, 0);
    check("t3_ovf", 40'(ovf), 40'd1);
    check("t3_tvalid", 40'(tvalid), 40'd1);
    check("t3_busy", 40'(busy), 40'd1);
    wait_idle("t3_idle");
    check("t3_ovf_sticky", 40'(ovf), 40'd1);

    // samples in IDLE are ignored; start during capture is ignored
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sv = 1'b1;
      sample = 12'(i + 9);
      sl = (i == 3);
      step();
      check("idle_tvalid", 40'(tvalid), 40'd0);
      check("idle_busy", 40'(busy), 40'd0);
    end
    sv = 1'b0;
    sl = 1'b0;
    for (int i = 0; i < 6; i++) smp[i] = 12'(i + 16);
    expect_frame(6, 0);
    send_frame(6, 1, 2, 1);
    check("t4_ovf_cleared", 40'(ovf), 40'd0);
    wait_idle("t4_idle");

    // asynchronous reset with words queued and overflow set
    for (int i = 0; i < 40; i++) smp[i] = 12'(i * 5 + 1);
    send_frame(40, 0, -1, 0);
    check("t5_pre_tvalid", 40'(tvalid), 40'd1);
    check("t5_pre_ovf", 40'(ovf), 40'd1);
    rst_n = 1'b0;
    #1;
    check("t5_tvalid", 40'(tvalid), 40'd0);
    check("t5_busy", 40'(busy), 40'd0);
    check("t5_adc_work", 40'(adc_work), 40'd0);
    check("t5_ovf", 40'(ovf), 40'd0);
    check("t5_out", 40'({tlast, tkeep, tdata}), 40'd0);
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) smp[i] = 12'(i + 12'h7A1);
    expect_frame(4, 0);
    send_frame(4, 1, -1, 1);
    wait_idle("t5_idle");

    // long frame with tready alternating
    for (int i = 0; i < 1000; i++) smp[i] = 12'(i * 37 + 5);
    words_seen = 0;
    expect_frame(1000, 0);
    send_frame(1000, 1, -1, 2);
    wait_idle("t6_idle");
    check("t6_ovf", 40'(ovf), 40'd0);
    check("t6_words", 40'(words_seen), 40'd500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/adc_stream_packer.md
# adc_stream_packer

Sits directly downstream of the CMOS ADC capture stage and upstream of the DMA. Starts a capture frame, accepts 12-bit samples, and packs two samples per 32-bit AXI4-Stream word. Words are buffered in a small FIFO so short DMA back-pressure is absorbed, and the final word of the frame carries `tlast`. The ADC side cannot be stalled: lost words are flagged, never silently hidden.

## Interface
- `SAMPLE_W`, 12, ADC sample width; each sample is zero-extended to 16 bits in the packed word.
- `FIFO_DEPTH`, 16, word FIFO depth; must be a power of two, ≥ 4.
- `i_CMOS_Clk` in 1: single clock for the whole block.
- `i_Rst_n` in 1: reset, asynchronous, active-low.
- `i_Start` in 1: one-cycle request to begin a frame; honoured only in IDLE.
- `o_ADC_Work` in the out direction, 1 bit: capture enable to the ADC stage; high for the whole CAPTURE state.
- `i_Sample_Valid` in 1: a sample is present this cycle.
- `i_Sample` in SAMPLE_W: sample data.
- `i_Sample_Last` in 1: qualifies the final sample of the frame; meaningful only with valid.
- `m_axis_tdata` out 32: packed word; first sample in [15:0], second sample in [31:16].
- `m_axis_tkeep` out 4: byte enables.
- `m_axis_tvalid` out 1.
- `m_axis_tready` in 1.
- `m_axis_tlast` out 1: final word of the frame.
- `o_Busy` out 1: high whenever state ≠ IDLE.
- `o_Overflow` out 1: sticky; set when a word is dropped; cleared on an accepted `i_Start`.

## Operation
- Reset: state IDLE; half-word slot empty; FIFO empty; last-pending flag clear. All outputs are 0.
- FSM:
  - IDLE → CAPTURE on `i_Start`. The same edge clears `o_Overflow` and the slot.
  - CAPTURE → DRAIN on the edge that accepts a sample with `i_Sample_Last` = 1.
  - DRAIN → IDLE on the edge where `tvalid & tready & tlast`.
  - `i_Start` is ignored in CAPTURE and DRAIN.
- A sample is accepted when `i_Sample_Valid` is high in CAPTURE. Samples arriving in IDLE or DRAIN are discarded and do not set overflow.
- Packing:
  - First accepted sample goes into the holding slot.
  - Second accepted sample forms the word {4'b0, s1, 4'b0, s0} with `tkeep` = 4'hF, and the slot empties.
- A last sample arriving in the first slot produces the word {16'b0, 4'b0, s0} with `tkeep` = 4'h3 and `tlast` = 1. A last sample in the second slot gives `tkeep` = 4'hF and `tlast` = 1.
- FIFO entry holds {tlast, tkeep, tdata} (37 bits).
- If the FIFO is full on a word write:
  - The word is dropped and `o_Overflow` is set.
  - If the dropped word carried `tlast`, the last-pending flag is set instead.
  - While last-pending is set and the FIFO is not full, the block writes one null word: data 0, `tkeep` = 4'h0, `tlast` = 1. The flag then clears.
  - This guarantees every frame terminates with `tlast`.
- `o_ADC_Work` = (state == CAPTURE). It is registered and drops the cycle after the last sample is accepted.

## Timing
- FIFO is first-word-fall-through. `m_axis_tvalid` = FIFO not empty; tdata, tkeep and tlast come straight from the FIFO head.
- Latency: the second (or last) sample is accepted in cycle N, and `tvalid` with that word is visible in cycle N+1.
- AXIS rules:
  - Once `tvalid` is asserted, `tdata`, `tkeep` and `tlast` stay stable until `tready`.
  - One word is popped per cycle with `tvalid & tready`.
- Simultaneous push and pop when full: the pop frees space on the same edge, so the push succeeds and nothing is dropped.
- Sustained input of 1 sample/cycle yields 1 word per 2 cycles. With `tready` held high, overflow never occurs.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-frame: FIFO contents, the slot and the flags are discarded immediately, and outputs go to 0 asynchronously.

## Structure
- Package `adc_stream_pkg`:
  - state enum {IDLE, CAPTURE, DRAIN};
  - WORD_W = 32, KEEP_W = 4;
  - the FIFO entry struct {last, keep, data};
  - a `pack_pair` function.
- Sub-module `stream_fifo`: synchronous FWFT FIFO, parameterised by width and depth, with full/empty/count and async active-low reset. The packer FSM and slot logic live in the top module.

## Test plan
- Frame of 4 samples 0x001, 0x002, 0x003, 0x004 with tready = 1 → words 0x00020001 and 0x00040003, `tkeep` = F; second word has `tlast` = 1; state returns to IDLE.
- Frame of 3 samples 0xABC, 0x123, 0xFFF → second word is 0x00000FFF, `tkeep` = 3, `tlast` = 1.
- Frame of 40 back-to-back samples with tready = 0 throughout → 16 words retained and 4 dropped. `o_Overflow` = 1. Releasing tready yields 16 words, then a null word with `tkeep` = 0 and `tlast` = 1.
- `i_Start` pulsed during CAPTURE, and samples presented in IDLE → no state change, no words output.
- Reset asserted with 5 words queued → `tvalid`, `o_Busy`, `o_ADC_Work` and `o_Overflow` are 0 the same cycle. A subsequent frame outputs only new data.
- Frame of 1000 samples with tready toggling 50% → 500 words in order, no overflow, `tlast` only on the 500th word.
